// File: rtl/lc3b_mem_responder.sv
// lc3b_mem_responder: fixed-latency 16-bit word memory responder for an LC-3b style initiator
// Ports: clk/reset (sync, active-high); mem_read/mem_write request strobes held until mem_resp;
//        mem_address byte address, mem_wdata write data, mem_byte_enable {high,low} byte lanes;
//        mem_resp registered one-cycle completion pulse, mem_rdata read data, mem_err sticky protocol error.
module lc3b_mem_responder #(
    parameter int unsigned LATENCY   = 3,
    parameter int unsigned ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] mem_address,
    input  logic [15:0] mem_wdata,
    input  logic [1:0]  mem_byte_enable,
    output logic        mem_resp,
    output logic [15:0] mem_rdata,
    output logic        mem_err
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   we_q;
    logic [ADDR_BITS-1:0]   idx_q;
    logic [15:0]            wdata_q;
    logic [1:0]             be_q;
    logic [15:0]            rdata_q;
    logic                   err_q;
    logic [15:0]            mem [2**ADDR_BITS];
    logic                   accept, both, unused_addr;
    logic [ADDR_BITS-1:0]   rd_idx;
    logic                   rd_we;
    assign both        = mem_read & mem_write;
    assign accept      = (state_q == IDLE) && (mem_read ^ mem_write);
    assign unused_addr = ^mem_address;
    // On the entering edge from IDLE (LATENCY=1) the request is not latched yet, so look at the inputs.
    assign rd_idx = (state_q == IDLE) ? mem_address[ADDR_BITS:1] : idx_q;
    assign rd_we  = (state_q == IDLE) ? mem_write : we_q;
    // WAIT lasts LATENCY-1 cycles so that RESP lands exactly LATENCY cycles after acceptance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = (LATENCY == 1) ? RESP : WAIT;
                cnt_d   = 4'(LATENCY - 1);
            end
            WAIT: if (!mem_read && !mem_write) begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end else if (cnt_q == 4'd1) begin
                state_d = RESP;
                cnt_d   = 4'd0;
            end else begin
                cnt_d   = cnt_q - 4'd1;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= mem_write;
                idx_q   <= mem_address[ADDR_BITS:1];
                wdata_q <= mem_wdata;
                be_q    <= mem_byte_enable;
            end
            if (state_d == RESP && state_q != RESP && !rd_we) rdata_q <= mem[rd_idx];
            if (both && (state_q == IDLE || state_q == WAIT)) err_q <= 1'b1;
        end
    end
    // Storage is never cleared; a write commits on the edge that ends RESP unless reset wins.
    always_ff @(posedge clk) begin
        if (!reset && state_q == RESP && we_q) begin
            if (be_q[0]) mem[idx_q][7:0]  <= wdata_q[7:0];
            if (be_q[1]) mem[idx_q][15:8] <= wdata_q[15:8];
        end
    end
    assign mem_resp  = (state_q == RESP);
    assign mem_rdata = rdata_q;
    assign mem_err   = err_q;
endmodule

// File: tb/tb_lc3b_mem_responder.sv
// tb_lc3b_mem_responder: directed self-checking bench for lc3b_mem_responder (LATENCY=3, ADDR_BITS=8)
module tb_lc3b_mem_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [15:0] mem_address = 16'h0;
    logic [15:0] mem_wdata = 16'h0;
    logic [1:0]  mem_byte_enable = 2'b00;
    logic        mem_resp;
    logic [15:0] mem_rdata;
    logic        mem_err;
    int          total = 0;
    int          bad = 0;
    int          lat;
    int          hits;
    logic [15:0] rd;

    lc3b_mem_responder #(.LATENCY(3), .ADDR_BITS(8)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives a request at a negedge and returns the number of cycles until mem_resp (-1 if none in 20).
    task automatic xfer(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                        input logic [1:0] be, output int l, output logic [15:0] q);
        mem_read = r; mem_write = w; mem_address = a; mem_wdata = d; mem_byte_enable = be;
        l = -1; q = 16'hxxxx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (mem_resp) begin
                l = k; q = mem_rdata;
                break;
            end
        end
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("resp_single_pulse", {31'd0, mem_resp}, 32'd0);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_resp", {31'd0, mem_resp}, 32'd0);
        check("rst_rdata", {16'd0, mem_rdata}, 32'h0000);
        check("rst_err", {31'd0, mem_err}, 32'd0);
        reset = 1'b0;
        idle(1);
        xfer(1'b0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, lat, rd);
        check("wr_beef_lat", lat, 3);
        check("wr_rdata_hold", {16'd0, mem_rdata}, 32'h0000);
        idle(1);
        xfer(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, lat, rd);
        check("rd_beef_lat", lat, 3);
        check("rd_beef_data", {16'd0, rd}, 32'hBEEF);
        idle(1);
        xfer(1'b0, 1'b1, 16'h0011, 16'h1200, 2'b10, lat, rd);
        check("wr_hi_lat", lat, 3);
        check("rdata_hold_after_wr", {16'd0, mem_rdata}, 32'hBEEF);
        idle(1);
        xfer(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, lat, rd);
        check("rd_12ef", {16'd0, rd}, 32'h12EF);
        idle(1);
        xfer(1'b0, 1'b1, 16'h0202, 16'hA5A5, 2'b11, lat, rd);
        idle(1);
        xfer(1'b1, 1'b0, 16'h0002, 16'h0000, 2'b00, lat, rd);
        check("rd_alias", {16'd0, rd}, 32'hA5A5);
        idle(1);
        xfer(1'b0, 1'b1, 16'h0040, 16'h1234, 2'b11, lat, rd);
        xfer(1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, lat, rd);
        check("b2b_lat", lat, 4);
        check("b2b_raw", {16'd0, rd}, 32'h1234);
        idle(1);
        xfer(1'b0, 1'b1, 16'h0040, 16'hFFFF, 2'b00, lat, rd);
        check("be00_lat", lat, 3);
        idle(1);
        xfer(1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, lat, rd);
        check("be00_nochange", {16'd0, rd}, 32'h1234);
        idle(1);
        xfer(1'b0, 1'b1, 16'h0041, 16'h00CD, 2'b01, lat, rd);
        idle(1);
        xfer(1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, lat, rd);
        check("lo_byte_only", {16'd0, rd}, 32'h12CD);
        idle(1);
        mem_read = 1'b1; mem_address = 16'h0010;
        repeat (2) @(negedge clk);
        mem_read = 1'b0;
        hits = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_resp) hits++;
        end
        check("abort_no_resp", hits, 0);
        xfer(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, lat, rd);
        check("after_abort_lat", lat, 3);
        check("after_abort_data", {16'd0, rd}, 32'h12EF);
        idle(1);
        mem_read = 1'b1; mem_address = 16'h0010;
        @(negedge clk);
        mem_address = 16'h0002;
        hits = 0; lat = -1;
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            if (mem_resp && lat < 0) begin lat = k; rd = mem_rdata; end
        end
        mem_read = 1'b0;
        check("wait_change_lat", lat, 3);
        check("wait_change_data", {16'd0, rd}, 32'h12EF);
        idle(1);
        mem_read = 1'b1; mem_write = 1'b1; mem_address = 16'h0010;
        @(negedge clk);
        check("both_idle_err", {31'd0, mem_err}, 32'd1);
        hits = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (mem_resp) hits++;
        end
        check("both_idle_no_resp", hits, 0);
        mem_read = 1'b0; mem_write = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("err_cleared", {31'd0, mem_err}, 32'd0);
        idle(1);
        mem_read = 1'b1; mem_address = 16'h0002;
        @(negedge clk);
        mem_write = 1'b1;
        lat = -1;
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            if (mem_resp && lat < 0) begin lat = k; rd = mem_rdata; end
        end
        mem_read = 1'b0; mem_write = 1'b0;
        check("both_wait_err", {31'd0, mem_err}, 32'd1);
        check("both_wait_lat", lat, 3);
        check("both_wait_data", {16'd0, rd}, 32'hA5A5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle(1);
        xfer(1'b0, 1'b1, 16'h0020, 16'h5555, 2'b11, lat, rd);
        idle(1);
        mem_write = 1'b1; mem_address = 16'h0020; mem_wdata = 16'h0000; mem_byte_enable = 2'b11;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_wait_resp", {31'd0, mem_resp}, 32'd0);
        reset = 1'b0; mem_write = 1'b0;
        hits = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (mem_resp) hits++;
        end
        check("rst_wait_no_resp", hits, 0);
        check("rst_wait_rdata", {16'd0, mem_rdata}, 32'h0000);
        xfer(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, lat, rd);
        check("rst_no_commit", {16'd0, rd}, 32'h5555);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lc3b_mem_responder.md
LC3B_MEM_RESPONDER -- requirements
Module: lc3b_mem_responder

Interface
REQ-001 Parameter LATENCY, default 3, cycles from request acceptance to mem_resp; legal range 1..15.
REQ-002 Parameter ADDR_BITS, default 8, log2 of word storage depth (256 x 16-bit words by default).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 mem_read  input  1  initiator read request, held until mem_resp.
REQ-006 mem_write  input  1  initiator write request, held until mem_resp.
REQ-007 mem_address  input  16 (lc3b_word)  byte address; held stable while request high.
REQ-008 mem_wdata  input  16 (lc3b_word)  write data; held stable while mem_write high.
REQ-009 mem_byte_enable  input  2 (lc3b_mem_wmask)  bit0 = low byte [7:0], bit1 = high byte [15:8].
REQ-010 mem_resp  output  1  one-cycle completion pulse.
REQ-011 mem_rdata  output  16 (lc3b_word)  read data, valid when mem_resp high on a read.
REQ-012 mem_err  output  1  sticky protocol-error flag.

Function
REQ-013 Word index SHALL be mem_address[ADDR_BITS:1]; mem_address[0] and bits above ADDR_BITS ignored (addresses alias/wrap).
REQ-014 States: IDLE, WAIT, RESP.
REQ-015 IDLE: exactly one of mem_read/mem_write high -> accept; latch op, index, wdata, byte_enable; load counter; go WAIT.
REQ-016 Acceptance in cycle 0 -> mem_resp high in cycle LATENCY exactly (LATENCY=1: next cycle); no other cycle.
REQ-017 WAIT: counter decrements each cycle; at terminal count -> RESP.
REQ-018 RESP: mem_resp = 1 for exactly one cycle; then IDLE unconditionally.
REQ-019 mem_resp SHALL be driven from a register (no combinational path from inputs).
REQ-020 Read: mem_rdata = stored word at latched index during RESP cycle; mem_rdata holds that value until next read response.
REQ-021 Write: commit at the clock edge ending the RESP cycle; only bytes with byte_enable bit set are modified; byte_enable = 2'b00 -> no change, mem_resp still pulses.
REQ-022 Read-after-write, same address, back-to-back: read SHALL return the newly written data.
REQ-023 Back-to-back: a request present in the cycle after RESP SHALL be accepted in that cycle (no dead cycle beyond IDLE).
REQ-024 Request withdrawn (both low) during WAIT -> abort to IDLE, no mem_resp, no memory update.
REQ-025 Request inputs changing during WAIT otherwise -> ignored; latched values used.
REQ-026 mem_read and mem_write both high in IDLE -> not accepted, stay IDLE, set mem_err; mem_err remains set until reset.
REQ-027 mem_read and mem_write both high during WAIT -> set mem_err, continue latched operation.

Reset
REQ-028 reset high at a rising edge -> state IDLE, counter 0, mem_resp 0, mem_rdata 16'h0000, mem_err 0.
REQ-029 reset mid-operation (WAIT or RESP) SHALL abort: no mem_resp in following cycle, pending write not committed.
REQ-030 Storage contents are not cleared by reset; unwritten locations read as X in simulation.
REQ-031 reset takes priority over all requests in the same cycle.

Verification
REQ-032 LATENCY=3: write 16'hBEEF to 16'h0010, be=2'b11, then read 16'h0010 -> mem_resp exactly 3 cycles after each acceptance, read returns 16'hBEEF.
REQ-033 After REQ-032: write 16'h1200 to 16'h0011, be=2'b10 -> read 16'h0010 returns 16'h12EF (bit0 ignored, high byte only).
REQ-034 Write 16'hA5A5 to 16'h0202 (ADDR_BITS=8) -> read 16'h0002 returns 16'hA5A5 (wrap/alias).
REQ-035 Read asserted, dropped after 1 cycle of WAIT -> no mem_resp over next 20 cycles; next read accepted normally.
REQ-036 mem_read and mem_write both high in IDLE -> mem_err = 1 next cycle, no mem_resp; reset -> mem_err = 0.
REQ-037 Reset asserted during WAIT of a write to 16'h0020 (data 16'h0000 over prior 16'h5555) -> no mem_resp; subsequent read of 16'h0020 returns 16'h5555.
